uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
Command sequencer behind the UART receiver. It consumes the receiver's byte and done-strobe stream and parses fixed-length framed packets (SYNC, ADDR, DATA, optional CSUM). Each good packet becomes one register-write request on a valid/ready interface toward the board register file. Framing errors, inter-byte timeouts and write overruns are reported as 1-cycle error pulses.

Parameters:
SYNC_BYTE, 8'hA5, start-of-packet marker
TIMEOUT_CLKS, 1000, max clk cycles allowed between consecutive bytes inside a packet (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
rx_byte  input  8  received byte; valid only in the cycle rx_done=1
rx_done  input  1  1-cycle strobe, one per received byte
wr_valid  output  1  write request pending
wr_addr  output  8  register address of pending write
wr_data  output  8  write data of pending write
wr_ready  input  1  consumer accepts; handshake when wr_valid & wr_ready at posedge
err_csum  output  1  1-cycle pulse: checksum mismatch, packet dropped
err_timeout  output  1  1-cycle pulse: inter-byte timeout, packet aborted
err_overflow  output  1  1-cycle pulse: packet completed while previous write still pending, new packet dropped
busy  output  1  parser not in S_IDLE

Behaviour:
- Reset (rst=0, async): state S_IDLE; wr_valid, wr_addr, wr_data, all err_*, busy = 0; timeout counter = 0; checksum accumulator = 0.
- All outputs registered; all state changes at posedge clk, only on rx_done or timeout.
- States: S_IDLE, S_ADDR, S_DATA, S_CSUM (S_CSUM only with feature enabled).
- S_IDLE: rx_done & rx_byte==SYNC_BYTE -> S_ADDR, accumulator = SYNC_BYTE; any other byte ignored silently.
- S_ADDR: rx_done -> latch addr, accumulate, -> S_DATA.
- S_DATA: rx_done -> latch data, accumulate; -> S_CSUM (feature on) or packet complete, -> S_IDLE (feature off).
- S_CSUM: rx_done -> packet complete if (accumulator + rx_byte) mod 256 == 0, else err_csum pulse; -> S_IDLE either way.
- SYNC_BYTE value inside ADDR/DATA/CSUM positions is plain data; no resync.
- Packet complete at edge T: if wr_valid=1 & wr_ready=0 in that cycle -> err_overflow pulse at T+1, new packet discarded, pending write unchanged. Otherwise wr_addr/wr_data load and wr_valid=1 from T+1 (latency: 1 clk after last byte's rx_done). A handshake in the same cycle as completion permits the load.
- wr_valid stays high with wr_addr/wr_data stable until handshake; cleared the cycle after handshake unless reloaded per above.
- Timeout: counter cleared on every rx_done and while in S_IDLE; otherwise increments each clk. Reaching TIMEOUT_CLKS-1 without rx_done -> S_IDLE, err_timeout pulse next cycle, partial packet discarded. rx_done in the same cycle as expiry wins: byte accepted, no timeout.
- Timeout/csum errors never disturb a pending write.
- Counter width $clog2(TIMEOUT_CLKS); no wrap possible.
- busy = (state != S_IDLE), registered with state.
- Reset mid-packet or mid-pending-write: everything cleared, pending write lost, no error pulse.

Optional Feature:
UART_CMD_CSUM_EN: defined -> 4-byte packets with S_CSUM; sum of all 4 bytes mod 256 must be 0. Undefined -> 3-byte packets, S_CSUM and checksum logic absent, err_csum tied 0.

Test Plan:
- Feature on: bytes A5,10,3C,0F, wr_ready=1 -> one cycle of wr_valid=1, wr_addr=0x10, wr_data=0x3C, no errors.
- Feature on: A5,10,3C,0E -> err_csum pulse once, wr_valid stays 0, busy=0 after last byte.
- A5,20 then 1000 idle clks (TIMEOUT_CLKS=1000) -> err_timeout pulse, busy=0; following A5,21,55,35 accepted as addr 0x21 data 0x55.
- wr_ready=0: packets (0x01,0xAA) then (0x02,0xBB) -> first held stable, err_overflow on second; assert wr_ready -> only addr 0x01 written.
- Noise 00,FF,5A then A5,A5,A5,71 -> noise ignored; write addr 0xA5 data 0xA5.
- rst low during S_DATA with a write pending -> all outputs 0 immediately; next full packet parsed normally.

Source files
------------

// File: rtl/uart_cmd_ctrl_if.sv
// Register-write request channel from the UART command parser to the board register file.
// Valid/ready: master holds wr_valid, wr_addr and wr_data stable until wr_valid & wr_ready at posedge.
`timescale 1ns/1ps
interface uart_cmd_ctrl_if;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Parses SYNC/ADDR/DATA[/CSUM] packets from the UART byte stream into register writes; UART_CMD_CSUM_EN adds the checksum byte.
// Latency: wr_valid rises 1 clk after the rx_done of the packet's last byte; error pulses are 1 clk after their cause.
// Backpressure: a pending write holds until wr_ready; a packet completing while it is blocked is dropped with err_overflow.
`timescale 1ns/1ps
module uart_cmd_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rx_byte,
    input  logic            rx_done,
    uart_cmd_ctrl_if.master wr,
    output logic            err_csum,
    output logic            err_timeout,
    output logic            err_overflow,
    output logic            busy
);
    localparam int             CW       = $clog2(TIMEOUT_CLKS);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CLKS - 1);

`ifdef UART_CMD_CSUM_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2, S_CSUM = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} state_t;
`endif

    state_t        state, nxt;
    logic [CW-1:0] tmo_cnt;
    logic [7:0]    addr_q;
    logic [7:0]    pkt_data;
    logic          tmo_hit, pkt_done, overflow, load;
    logic          wr_valid_q;
    logic [7:0]    wr_addr_q, wr_data_q;

`ifdef UART_CMD_CSUM_EN
    logic [7:0]    data_q, acc, csum_sum;
    logic          csum_bad;
    assign csum_sum = acc + rx_byte;
    assign pkt_data = data_q;
`else
    assign pkt_data = rx_byte;
    assign err_csum = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= nxt;
            busy  <= (nxt != S_IDLE);
        end
    end

    // A byte arriving in the expiry cycle takes priority over the timeout.
    always_comb begin
        nxt     = state;
        tmo_hit = 1'b0;
        if (state != S_IDLE && !rx_done && tmo_cnt == TMO_LAST) begin
            tmo_hit = 1'b1;
            nxt     = S_IDLE;
        end else if (rx_done) begin
            case (state)
                S_IDLE:  if (rx_byte == SYNC_BYTE) nxt = S_ADDR;
                S_ADDR:  nxt = S_DATA;
`ifdef UART_CMD_CSUM_EN
                S_DATA:  nxt = S_CSUM;
                S_CSUM:  nxt = S_IDLE;
`else
                S_DATA:  nxt = S_IDLE;
`endif
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pkt_done = 1'b0;
`ifdef UART_CMD_CSUM_EN
        csum_bad = 1'b0;
        if (rx_done && state == S_CSUM) begin
            if (csum_sum == 8'd0) pkt_done = 1'b1;
            else                  csum_bad = 1'b1;
        end
`else
        if (rx_done && state == S_DATA) pkt_done = 1'b1;
`endif
        // A handshake in the completion cycle frees the slot, so only a blocked write overflows.
        overflow = pkt_done && wr_valid_q && !wr.wr_ready;
        load     = pkt_done && !overflow;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt      <= '0;
            addr_q       <= 8'd0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= 8'd0;
            wr_data_q    <= 8'd0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
`ifdef UART_CMD_CSUM_EN
            data_q       <= 8'd0;
            acc          <= 8'd0;
            err_csum     <= 1'b0;
`endif
        end else begin
            tmo_cnt <= (rx_done || state == S_IDLE || tmo_hit) ? '0 : tmo_cnt + 1'b1;
            if (rx_done && state == S_ADDR) addr_q <= rx_byte;
`ifdef UART_CMD_CSUM_EN
            if (rx_done && state == S_DATA) data_q <= rx_byte;
            if (rx_done) acc <= (state == S_IDLE) ? SYNC_BYTE : csum_sum;
            err_csum <= csum_bad;
`endif
            if (load) begin
                wr_valid_q <= 1'b1;
                wr_addr_q  <= addr_q;
                wr_data_q  <= pkt_data;
            end else if (wr_valid_q && wr.wr_ready) begin
                wr_valid_q <= 1'b0;
            end
            err_timeout  <= tmo_hit;
            err_overflow <= overflow;
        end
    end

    assign wr.wr_valid = wr_valid_q;
    assign wr.wr_addr  = wr_addr_q;
    assign wr.wr_data  = wr_data_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: table-driven packets, directed corner sequences, and random traffic
// checked every cycle against a byte-queue reference model.
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TMO  = 1000;
`ifdef UART_CMD_CSUM_EN
    localparam int PKT_LEN = 4;
    localparam bit CSUM_ON = 1'b1;
`else
    localparam int PKT_LEN = 3;
    localparam bit CSUM_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_done = 1'b0;
    logic       err_csum, err_timeout, err_overflow, busy;

    uart_cmd_ctrl_if wif();

    uart_cmd_ctrl #(.SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_done(rx_done), .wr(wif),
        .err_csum(err_csum), .err_timeout(err_timeout), .err_overflow(err_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: bytes collect in a queue once a SYNC opens a packet; a full queue
    // is judged by its byte sum; an idle gap of TMO clocks inside a packet empties it.
    logic [7:0] mq[$];
    int         gap = 0;
    bit         m_pend = 1'b0;
    logic [7:0] m_addr = 8'h00, m_data = 8'h00;
    bit         m_csum = 1'b0, m_tmo = 1'b0, m_ovf = 1'b0;
    bit         model_on = 1'b0;
    bit         rnd_rdy = 1'b0;

    task automatic model_step();
        int s;
        bit done;
        logic [7:0] a, d;
        done = 1'b0; a = 8'h00; d = 8'h00;
        m_csum = 1'b0; m_tmo = 1'b0; m_ovf = 1'b0;
        if (rx_done) begin
            if (mq.size() > 0 || rx_byte == SYNC) mq.push_back(rx_byte);
            gap = 0;
            if (mq.size() == PKT_LEN) begin
                s = 0;
                foreach (mq[i]) s += int'(mq[i]);
                if (CSUM_ON && (s % 256) != 0) m_csum = 1'b1;
                else begin done = 1'b1; a = mq[1]; d = mq[2]; end
                mq.delete();
            end
        end else if (mq.size() > 0) begin
            gap++;
            if (gap >= TMO) begin mq.delete(); m_tmo = 1'b1; gap = 0; end
        end
        if (done && m_pend && !wif.wr_ready) m_ovf = 1'b1;
        else if (done) begin m_pend = 1'b1; m_addr = a; m_data = d; end
        else if (m_pend && wif.wr_ready) m_pend = 1'b0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete(); gap = 0; m_pend = 1'b0;
            m_csum = 1'b0; m_tmo = 1'b0; m_ovf = 1'b0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            logic [31:0] act, exp;
            act = {wif.wr_valid, (wif.wr_valid ? {wif.wr_addr, wif.wr_data} : 16'h0000),
                   err_csum, err_timeout, err_overflow, busy};
            exp = {m_pend, (m_pend ? {m_addr, m_data} : 16'h0000),
                   m_csum, m_tmo, m_ovf, (mq.size() != 0)};
            check("model", act, exp);
        end
    end

    task automatic tick(input bit dv, input logic [7:0] b);
        rx_done = dv;
        rx_byte = b;
        if (rnd_rdy) wif.wr_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    function automatic logic [7:0] csum_of(input logic [7:0] a, input logic [7:0] d);
        return 8'h00 - SYNC - a - d;
    endfunction

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] d, input bit bad);
        logic [7:0] c;
        c = csum_of(a, d) - {7'd0, bad};
        tick(1'b1, SYNC);
        tick(1'b1, a);
        tick(1'b1, d);
        if (CSUM_ON) tick(1'b1, c);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        bit         bad;
        bit         exp_wr;
        bit         exp_cerr;
    } vec_t;
    vec_t vt[6];

    initial begin
        logic [7:0] c;
        int g;
        vt[0] = '{8'h10, 8'h3C, 1'b0, 1'b1, 1'b0};
        vt[1] = '{8'h10, 8'h3C, 1'b1, !CSUM_ON, CSUM_ON};
        vt[2] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vt[3] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0};
        vt[4] = '{8'hA5, 8'h5A, 1'b1, !CSUM_ON, CSUM_ON};
        vt[5] = '{8'h7E, 8'hA5, 1'b0, 1'b1, 1'b0};

        wif.wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", wif.wr_valid, 1'b0);
        check("rst_addr", wif.wr_addr, 8'h00);
        check("rst_data", wif.wr_data, 8'h00);
        check("rst_errs", {err_csum, err_timeout, err_overflow}, 3'b000);
        check("rst_busy", busy, 1'b0);
        rst = 1'b1;
        model_on = 1'b1;

        wif.wr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_pkt(vt[i].addr, vt[i].data, vt[i].bad);
            check("tbl_valid", wif.wr_valid, vt[i].exp_wr);
            if (vt[i].exp_wr) check("tbl_addr_data", {wif.wr_addr, wif.wr_data}, {vt[i].addr, vt[i].data});
            check("tbl_csum_err", err_csum, vt[i].exp_cerr);
            check("tbl_busy", busy, 1'b0);
            idle(1);
            check("tbl_drained", {wif.wr_valid, err_csum}, 2'b00);
        end

        // Inter-byte timeout, then recovery.
        tick(1'b1, SYNC); tick(1'b1, 8'h20);
        check("tmo_busy", busy, 1'b1);
        idle(TMO - 1);
        check("tmo_not_yet", {err_timeout, busy}, 2'b01);
        idle(1);
        check("tmo_pulse", {err_timeout, busy}, 2'b10);
        idle(1);
        check("tmo_clear", err_timeout, 1'b0);
        send_pkt(8'h21, 8'h55, 1'b0);
        check("tmo_recover", {wif.wr_valid, wif.wr_addr, wif.wr_data}, {1'b1, 8'h21, 8'h55});
        tick(1'b1, 8'h35);
        check("trail_ignored", busy, 1'b0);
        idle(2);

        // A byte landing exactly in the expiry cycle is accepted.
        tick(1'b1, SYNC); idle(TMO - 1); tick(1'b1, 8'h44);
        check("tmo_edge_win", {err_timeout, busy}, 2'b01);
        tick(1'b1, 8'h66);
        c = csum_of(8'h44, 8'h66);
        if (CSUM_ON) tick(1'b1, c);
        check("tmo_edge_wr", {wif.wr_valid, wif.wr_addr, wif.wr_data}, {1'b1, 8'h44, 8'h66});
        idle(2);

        // Overflow while a write is blocked.
        wif.wr_ready = 1'b0;
        send_pkt(8'h01, 8'hAA, 1'b0);
        check("ovf_first", {wif.wr_valid, wif.wr_addr, wif.wr_data}, {1'b1, 8'h01, 8'hAA});
        send_pkt(8'h02, 8'hBB, 1'b0);
        check("ovf_pulse", err_overflow, 1'b1);
        check("ovf_held", {wif.wr_valid, wif.wr_addr, wif.wr_data}, {1'b1, 8'h01, 8'hAA});
        idle(1);
        check("ovf_clear", {err_overflow, wif.wr_valid}, 2'b01);
        wif.wr_ready = 1'b1;
        idle(1);
        check("ovf_drain", wif.wr_valid, 1'b0);

        // Handshake in the completion cycle lets the new write load.
        wif.wr_ready = 1'b0;
        send_pkt(8'h03, 8'hCC, 1'b0);
        c = csum_of(8'h04, 8'hDD);
        tick(1'b1, SYNC); tick(1'b1, 8'h04);
        if (CSUM_ON) tick(1'b1, 8'hDD);
        wif.wr_ready = 1'b1;
        tick(1'b1, CSUM_ON ? c : 8'hDD);
        check("same_cycle_hs", {err_overflow, wif.wr_valid, wif.wr_addr, wif.wr_data}, {1'b0, 1'b1, 8'h04, 8'hDD});
        idle(2);

        // Noise before a packet whose payload repeats the SYNC value.
        tick(1'b1, 8'h00); tick(1'b1, 8'hFF); tick(1'b1, 8'h5A);
        check("noise_idle", busy, 1'b0);
        send_pkt(8'hA5, 8'hA5, 1'b0);
        check("sync_as_data", {wif.wr_valid, wif.wr_addr, wif.wr_data}, {1'b1, 8'hA5, 8'hA5});
        tick(1'b1, 8'h71);
        check("noise_after", busy, 1'b0);
        idle(2);

        // Asynchronous reset mid-packet with a write pending.
        wif.wr_ready = 1'b0;
        send_pkt(8'h33, 8'h44, 1'b0);
        tick(1'b1, SYNC); tick(1'b1, 8'h12);
        check("pre_rst", {wif.wr_valid, busy}, 2'b11);
        #2 rst = 1'b0;
        #1;
        check("async_rst", {wif.wr_valid, wif.wr_addr, wif.wr_data, err_csum, err_timeout, err_overflow, busy}, 21'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        wif.wr_ready = 1'b1;
        send_pkt(8'h55, 8'h66, 1'b0);
        check("post_rst_wr", {wif.wr_valid, wif.wr_addr, wif.wr_data}, {1'b1, 8'h55, 8'h66});
        idle(2);

        // Random traffic against the model.
        rnd_rdy = 1'b1;
        for (int p = 0; p < 200; p++) begin
            int kind;
            logic [7:0] b[4];
            kind = int'($urandom_range(0, 9));
            b[0] = SYNC;
            b[1] = 8'($urandom);
            b[2] = 8'($urandom);
            b[3] = (kind == 1) ? 8'($urandom) : csum_of(b[1], b[2]);
            if (kind == 0) b[0] = 8'($urandom);
            for (int k = 0; k < PKT_LEN; k++) begin
                g = ($urandom_range(0, 29) == 0) ? int'($urandom_range(TMO - 2, TMO + 1))
                                                 : int'($urandom_range(0, 2));
                idle(g);
                tick(1'b1, b[k]);
            end
        end
        rnd_rdy = 1'b0;
        wif.wr_ready = 1'b1;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
